// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared types and constants for axis_uart_ask_tx_multi.
//   uart_state_e : transmitter FSM states
//   PAR_*        : encodings of the run-time parity port
//   MIN_DIV      : smallest usable clocks-per-bit; smaller requests clamp to it
package uart_tx_pkg;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int MIN_DIV = 2;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO, 2^FIFO_AW words, first-word-fall-through read.
//   clk, rst     : clock, synchronous active-low reset (empties the FIFO)
//   wr_en/wr_data: push (ignored when full)
//   rd_en/rd_data: pop (ignored when empty); rd_data shows the head word
//   level        : occupancy, full/empty decoded from it
//   not_full_q   : registered "room available", low during reset
module uart_tx_fifo
  import uart_tx_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               rd_en,
  output logic [DATA_W-1:0]  rd_data,
  output logic [FIFO_AW:0]   level,
  output logic               full,
  output logic               empty,
  output logic               not_full_q
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_LVL = {1'b1, {FIFO_AW{1'b0}}};

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [FIFO_AW-1:0] wp, rp;
  logic               do_wr, do_rd;
  logic [FIFO_AW:0]   lvl_nxt;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rp];

  always_comb begin
    lvl_nxt = level;
    if (do_wr && !do_rd)      lvl_nxt = level + 1'b1;
    else if (!do_wr && do_rd) lvl_nxt = level - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wp         <= '0;
      rp         <= '0;
      level      <= '0;
      not_full_q <= 1'b0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
      level      <= lvl_nxt;
      // Built from the next level so ready drops right after the filling write,
      // and a same-cycle pop cannot reopen it.
      not_full_q <= (lvl_nxt != FULL_LVL);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wp] <= wr_data;
  end
endmodule

// File: rtl/axis_uart_ask_tx_multi.sv
// axis_uart_ask_tx_multi: AXI-Stream fed serial transmitter with NRZ and ASK outputs.
// Words are buffered in uart_tx_fifo and sent LSB-first as
// start / DATA_W data / optional parity / 1 or 2 stop bits.
//   clk, rst          : clock, synchronous active-low reset (aborts frame, flushes FIFO)
//   i_tdata/i_tvalid/i_tready : AXI-Stream input, ready = registered not-full
//   clkdiv            : clocks per bit (0,1 act as 2), latched at frame start
//   stop2             : two stop bits, latched at frame start
//   parity            : 00/11 none, 01 even, 10 odd, latched at frame start
//   tx                : NRZ line, idle high
//   ask_tx            : [1] carrier enable (= ~tx), [0] gated carrier
//   busy              : frame in progress
//   level             : FIFO occupancy
// Build option: define UART_TX_PARITY_EN to build the parity bit; otherwise the
// parity port is ignored and frames never carry parity.
module axis_uart_ask_tx_multi
  import uart_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int FIFO_AW      = 4,
  parameter int DIV_W        = 16,
  parameter int CARRIER_HALF = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_tdata,
  input  logic              i_tvalid,
  output logic              i_tready,
  input  logic [DIV_W-1:0]  clkdiv,
  input  logic              stop2,
  input  logic [1:0]        parity,
  output logic              tx,
  output logic [1:0]        ask_tx,
  output logic              busy,
  output logic [FIFO_AW:0]  level
);
  localparam int CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

  uart_state_e       state;
  logic [DIV_W-1:0]  div_q, cnt, div_in;
  logic [DATA_W-1:0] sr, fifo_q;
  logic [3:0]        bitcnt;
  logic              stop2_q, stop_2nd;
  logic              fifo_empty, unused_full;
  logic              push, pop, bit_end, last_stop, tx_d;
  logic [CW-1:0]     ccnt;
  logic              car, car_d, car_wrap;

  assign push      = i_tvalid && i_tready;
  assign div_in    = (clkdiv < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : clkdiv;
  assign bit_end   = (cnt == '0);
  assign last_stop = (state == ST_STOP) && bit_end && (!stop2_q || stop_2nd);
  // Popping straight out of the final stop period keeps back-to-back frames gapless.
  assign pop       = !fifo_empty && ((state == ST_IDLE) || last_stop);

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_bit_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else if (pop) begin
      par_en_q  <= (parity == PAR_EVEN) || (parity == PAR_ODD);
      par_bit_q <= (^fifo_q) ^ (parity == PAR_ODD);
    end
  end
`else
  logic unused_parity;
  assign unused_parity = ^parity;
`endif

  uart_tx_fifo #(.DATA_W(DATA_W), .FIFO_AW(FIFO_AW)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (push),
    .wr_data    (i_tdata),
    .rd_en      (pop),
    .rd_data    (fifo_q),
    .level      (level),
    .full       (unused_full),
    .empty      (fifo_empty),
    .not_full_q (i_tready)
  );

  // FSM + baud down-counter; cnt==0 marks the last clock of a bit period.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      div_q    <= DIV_W'(MIN_DIV);
      sr       <= '0;
      bitcnt   <= '0;
      stop2_q  <= 1'b0;
      stop_2nd <= 1'b0;
    end else if (pop) begin
      state    <= ST_START;
      div_q    <= div_in;
      cnt      <= div_in - 1'b1;
      sr       <= fifo_q;
      bitcnt   <= '0;
      stop2_q  <= stop2;
      stop_2nd <= 1'b0;
    end else begin
      if (state != ST_IDLE) cnt <= bit_end ? div_q - 1'b1 : cnt - 1'b1;
      if (bit_end) begin
        case (state)
          ST_START: state <= ST_DATA;
          ST_DATA: begin
            sr     <= sr >> 1;
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == 4'(DATA_W - 1)) begin
              bitcnt <= '0;
`ifdef UART_TX_PARITY_EN
              state  <= par_en_q ? ST_PARITY : ST_STOP;
`else
              state  <= ST_STOP;
`endif
            end
          end
`ifdef UART_TX_PARITY_EN
          ST_PARITY: state <= ST_STOP;
`endif
          ST_STOP: begin
            if (stop2_q && !stop_2nd) stop_2nd <= 1'b1;
            else begin
              stop_2nd <= 1'b0;
              state    <= ST_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Line level for the current state; registered below, so outputs trail the FSM by one clock.
  always_comb begin
    tx_d = 1'b1;
    case (state)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = sr[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = par_bit_q;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  assign car_wrap = (ccnt == CW'(CARRIER_HALF - 1));
  assign car_d    = car_wrap ? ~car : car;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ccnt   <= '0;
      car    <= 1'b0;
      tx     <= 1'b1;
      ask_tx <= 2'b00;
      busy   <= 1'b0;
    end else begin
      ccnt   <= car_wrap ? '0 : ccnt + 1'b1;
      car    <= car_d;
      tx     <= tx_d;
      ask_tx <= {~tx_d, car_d & ~tx_d};
      busy   <= (state != ST_IDLE);
    end
  end
endmodule

// File: tb/tb_axis_uart_ask_tx_multi.sv
module tb_axis_uart_ask_tx_multi;
  localparam int DATA_W = 8, FIFO_AW = 4, DIV_W = 16, CH = 2;

  logic              clk = 1'b0, rst = 1'b0;
  logic [DATA_W-1:0] i_tdata = '0;
  logic              i_tvalid = 1'b0, i_tready;
  logic [DIV_W-1:0]  clkdiv = 16'd12;
  logic              stop2 = 1'b0;
  logic [1:0]        parity = 2'b00;
  logic              tx, busy;
  logic [1:0]        ask_tx;
  logic [FIFO_AW:0]  level;

  int total = 0, bad = 0;

  axis_uart_ask_tx_multi #(.DATA_W(DATA_W), .FIFO_AW(FIFO_AW), .DIV_W(DIV_W), .CARRIER_HALF(CH)) dut (
    .clk(clk), .rst(rst), .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .clkdiv(clkdiv), .stop2(stop2), .parity(parity), .tx(tx), .ask_tx(ask_tx),
    .busy(busy), .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One handshake; returns on the negedge after the accepting edge (k=0).
  task automatic push1(input logic [7:0] d);
    @(negedge clk);
    i_tdata = d; i_tvalid = 1'b1;
    chk("push_rdy", i_tready, 1);
    @(negedge clk);
    i_tvalid = 1'b0;
  endtask

  // Checks one isolated frame cycle by cycle: tx low from k=2, each bit div clocks,
  // busy over the frame, ask_tx[1] = ~tx. clkdiv is disturbed mid-frame on purpose.
  task automatic run_frame(input string tag, input logic [15:0] bits, input int nb,
                           input int div, output logic [15:0] got);
    int  errs;
    int  last;
    logic e, be;
    errs = 0; last = 2 + nb * div; got = '0;
    for (int k = 0; k <= last; k++) begin
      e  = (k < 2 || k >= last) ? 1'b1 : bits[(k - 2) / div];
      be = (k >= 2 && k < last);
      if (tx !== e || ask_tx[1] !== ~e || busy !== be) errs++;
      if (be && ((k - 2) % div) == div / 2) got[(k - 2) / div] = tx;
      if (k == 3) clkdiv = 16'd7;
      @(negedge clk);
    end
    chk({tag, "_wave"}, errs, 0);
    chk({tag, "_idle"}, {busy, tx}, 2'b01);
  endtask

  logic [15:0] got;
  logic        wave [0:419];
  logic        bz   [0:419];
  logic [1:0]  ak   [0:59];
  int          errs, acc;
  logic        fire, stopped, e;
  logic [7:0]  w, lastw;

  initial begin
    // Reset held with valid asserted
    i_tvalid = 1'b1; i_tdata = 8'hA5;
    errs = 0;
    repeat (10) begin
      @(negedge clk);
      if (tx !== 1'b1 || ask_tx !== 2'b00 || level !== '0 || i_tready !== 1'b0 || busy !== 1'b0) errs++;
    end
    chk("rst_hold", errs, 0);
    chk("rst_tx", tx, 1);
    chk("rst_ask", ask_tx, 0);
    chk("rst_rdy", i_tready, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rdy_rise", i_tready, 1);
    chk("rst_noacc", level, 0);
    i_tvalid = 1'b0;
    repeat (3) @(negedge clk);

    // 8N1, div 12
    clkdiv = 16'd12;
    push1(8'h55);
    run_frame("8n1", {6'b0, 1'b1, 8'h55, 1'b0}, 10, 12, got);
    chk("8n1_bits", got[9:0], 10'b1010101010);

    // divider 0 clamps to 2
    clkdiv = 16'd0;
    push1(8'hC3);
    run_frame("div0", {6'b0, 1'b1, 8'hC3, 1'b0}, 10, 2, got);
    chk("div0_bits", got[9:0], {1'b1, 8'hC3, 1'b0});

    // Parity / two stop bits
    stop2 = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity = 2'b01; clkdiv = 16'd4;
    push1(8'h53);
    run_frame("even", {4'b0, 2'b11, 1'b0, 8'h53, 1'b0}, 12, 4, got);
    chk("even_par", got[9], 0);
    chk("even_stop", got[11:10], 2'b11);
    parity = 2'b10; clkdiv = 16'd4;
    push1(8'h53);
    run_frame("odd", {4'b0, 2'b11, 1'b1, 8'h53, 1'b0}, 12, 4, got);
    chk("odd_par", got[9], 1);
`else
    parity = 2'b01; clkdiv = 16'd4;
    push1(8'h53);
    run_frame("nopar", {5'b0, 2'b11, 8'h53, 1'b0}, 11, 4, got);
    chk("nopar_stop", got[10:9], 2'b11);
`endif
    stop2 = 1'b0; parity = 2'b00;

    // ASK: 0x00 keeps the carrier enabled for start + 8 data bits
    clkdiv = 16'd4;
    push1(8'h00);
    for (int k = 0; k < 50; k++) begin
      ak[k] = ask_tx;
      @(negedge clk);
    end
    errs = 0;
    for (int k = 2; k < 38; k++) begin
      if (ak[k][1] !== 1'b1) errs++;
      if (k >= 4 && ak[k][0] === ak[k - 2][0]) errs++;
    end
    chk("ask_car", errs, 0);
    errs = 0;
    for (int k = 38; k < 42; k++) if (ak[k] !== 2'b00) errs++;
    chk("ask_stop", errs, 0);

    // Burst: push until ready drops, then expect 17 gapless frames in order
    clkdiv = 16'd2;
    @(negedge clk);
    i_tvalid = 1'b1; i_tdata = 8'h08; acc = 0; stopped = 1'b0;
    chk("burst_rdy0", i_tready, 1);
    for (int c = 0; c < 420; c++) begin
      fire = i_tvalid && i_tready;
      @(negedge clk);
      if (fire) acc++;
      wave[c] = tx; bz[c] = busy;
      if (!stopped) begin
        if (!i_tready) begin
          stopped = 1'b1; i_tvalid = 1'b0;
          chk("burst_acc", acc, 17);
          chk("burst_lvl", level, 16);
        end else begin
          i_tdata = 8'h08 + 8'(acc);
        end
      end
    end
    chk("burst_stop", stopped, 1);
    errs = 0;
    for (int c = 0; c < 420; c++) begin
      if (c < 2 || c >= 342) e = 1'b1;
      else begin
        w = 8'h08 + 8'((c - 2) / 20);
        case (((c - 2) % 20) / 2)
          0:       e = 1'b0;
          9:       e = 1'b1;
          default: e = w[((c - 2) % 20) / 2 - 1];
        endcase
      end
      if (wave[c] !== e || bz[c] !== (c >= 2 && c < 342)) errs++;
    end
    chk("burst_wave", errs, 0);
    lastw = '0;
    for (int b = 0; b < 8; b++) lastw[b] = wave[322 + 2 * (b + 1)];
    chk("burst_last", lastw, 8'h18);

    // Abort mid-DATA with 3 words queued
    clkdiv = 16'd8;
    @(negedge clk);
    i_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_tdata = 8'hE0 + 8'(i);
      @(negedge clk);
    end
    i_tvalid = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_pre_lvl", level, 3);
    chk("abort_pre_busy", busy, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_tx", tx, 1);
    chk("abort_lvl", level, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ask", ask_tx, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    errs = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || level !== '0) errs++;
    end
    chk("abort_quiet", errs, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axis_uart_ask_tx_multi.md
# axis_uart_ask_tx_multi

Parametrised AXI-Stream serial transmitter; next generation of the fixed 8N1 UART/ASK wrappers. Sits between an AXI-Stream byte source and the RF/line front end. It buffers words in an internal FIFO and serialises them LSB-first with run-time baud divider, stop-bit count and parity. It drives the NRZ line (`tx`) and a 2-bit ASK on-off-keyed output (`ask_tx`) from the same bit stream.

## Interface
- `DATA_W`, 8: data bits per frame; legal range 5..9.
- `FIFO_AW`, 4: FIFO address width; depth is 2^FIFO_AW words.
- `DIV_W`, 16: width of the baud divider port.
- `CARRIER_HALF`, 2: clocks per ASK carrier half-period; minimum 1.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `i_tdata` in DATA_W: word to send.
- `i_tvalid` in 1: AXI-S valid.
- `i_tready` out 1: AXI-S ready; equals not-full.
- `clkdiv` in DIV_W: clocks per bit; values 0..1 are treated as 2.
- `stop2` in 1: 1 selects two stop bits.
- `parity` in 2: 00 none, 01 even, 10 odd, 11 none.
- `tx` out 1: NRZ line; idle high.
- `ask_tx` out 2: [1] carrier enable, [0] gated carrier.
- `busy` out 1: a frame is in progress.
- `level` out FIFO_AW+1: FIFO occupancy.

## Operation
- Accept: a word is written when `i_tvalid && i_tready`.
- Full FIFO: `i_tready` is low while the FIFO is full, even if a pop happens in the same cycle.
- Simultaneous push and pop on a non-full FIFO: `level` is unchanged.
- FSM states are IDLE, START, DATA, PARITY and STOP.
- IDLE: when the FIFO is non-empty, pop a word into the shift register. On that same edge, latch `clkdiv`, `stop2` and `parity`, then go to START. Config changes mid-frame have no effect until the next frame.
- START: drive `tx` = 0 for one bit period, then go to DATA.
- DATA: send DATA_W bits LSB-first, one per bit period, with a bit counter. After the last bit, go to PARITY if parity is enabled, otherwise to STOP.
- PARITY: drive the XOR of the data bits (even) or its inverse (odd) for one bit period.
- STOP: drive 1 for one bit period, or two if `stop2` was latched. Then return to IDLE.
- Back-to-back frames: IDLE with a non-empty FIFO pops immediately. The next start bit directly follows the last stop bit, with no idle gap.
- Bit period: exactly the latched divider value in clocks. A down-counter reloads at each bit boundary.
- ASK: `ask_tx[1]` = ~`tx` (carrier on during space).
- Carrier: a free-running toggle every CARRIER_HALF clocks.
- `ask_tx[0]` = carrier & `ask_tx[1]`; it is 0 whenever the enable is low.
- `busy` is 1 in every state except IDLE.
- Reset values: `tx`=1, `ask_tx`=00, `busy`=0, `level`=0, and `i_tready`=0 while `rst` is low.
- Reset mid-frame: the frame is aborted, the FIFO is emptied, and `tx` returns to 1 on the first clock edge with `rst` low.

## Timing
- All outputs are registered.
- First frame: with an empty FIFO and an idle FSM, a handshake at edge N makes the word visible in the FIFO at N+1. The pop occurs at N+1, and `tx` falls after edge N+2.
- `i_tready` rises the cycle after reset deasserts.
- `i_tready` deasserts at the edge after the write that fills the FIFO.
- Frame length in clocks is div×(1+DATA_W+P+S). P is 0 or 1 (parity bit). S is 1 or 2 (stop bits).

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined: the PARITY state exists and the `parity` port is honoured.
- Undefined: the PARITY state is not built and the `parity` port is ignored. Frames never carry a parity bit.

## Structure
- Package `uart_tx_pkg` holds:
  - the FSM state enum;
  - the parity-mode encodings (PAR_NONE, PAR_EVEN, PAR_ODD);
  - the minimum-divider constant (2).
- Sub-module `uart_tx_fifo` is a synchronous FIFO parametrised by DATA_W and FIFO_AW, with `level`, full and empty outputs.
- The FSM, the baud counter and the ASK carrier stay in the top module.

## Test plan
- Reset:
  - Stimulus: hold `rst` low for 10 clocks while `i_tvalid`=1.
  - Required response: `tx`=1, `ask_tx`=00, `level`=0, `i_tready`=0, and no word is accepted.
- 8N1:
  - Stimulus: `clkdiv`=12, parity none, send 0x55.
  - Required response: `tx` falls 2 cycles after the handshake. Bits 0,1,0,1,0,1,0,1,0,1 are each 12 clocks long, 120 clocks total, then `busy` falls.
- Burst:
  - Stimulus: FIFO_AW=4, push 17 words back-to-back.
  - Required response: `i_tready` drops after 17 accepted words (16 buffered plus 1 popped).
  - Then: all 17 frames leave with no idle gap, in order, ending in 0x18.
- Parity/stop:
  - Stimulus: even parity, `stop2`=1, send 0x53.
  - Required response: parity bit = 0, followed by 2 stop periods.
  - Odd parity: the parity bit = 1.
- ASK:
  - Stimulus: CARRIER_HALF=2, send 0x00.
  - Required response: `ask_tx[0]` toggles every 2 clocks for 9 bit periods and is 0 during the stop bit.
- Abort:
  - Stimulus: assert `rst` in the middle of DATA with 3 words queued.
  - Required response: next cycle `tx`=1, `level`=0, `busy`=0, and no further frames are sent after release.
